// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Owns the single write port of the integer register file. Writebacks from
//   the ALU and the load/store unit are arbitrated round-robin under
//   contention and are accepted through a valid/ready handshake. An accepted
//   result is driven onto a registered write port one cycle later. A
//   per-register pending scoreboard lets decode detect read-after-write
//   hazards on its two source operands.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   alu_valid    ALU result available
//   alu_rd       ALU destination register
//   alu_data     ALU result
//   alu_ready    ALU result accepted this cycle
//   lsu_valid    load data available
//   lsu_rd       load destination register
//   lsu_data     load data
//   lsu_ready    load result accepted this cycle
//   issue_valid  decode issues an instruction that writes issue_rd
//   issue_rd     destination of the issued instruction
//   flush        synchronous clear of the whole scoreboard
//   rs1, rs2     decode source registers
//   hazard1/2    source value in the register file is not yet valid
//   wb_en        register-file write enable
//   wb_addr      register-file write address
//   wb_data      register-file write data
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            hazard1,
   output logic            hazard2,
   output logic            wb_en,
   output logic [AW-1:0]   wb_addr,
   output logic [XLEN-1:0] wb_data
);

   // Round-robin pointer: names the requester that wins the next contention.
   typedef enum logic {
      PTR_ALU = 1'b0,
      PTR_LSU = 1'b1
   } rr_ptr_e;

   localparam logic [AW-1:0]    REG_ZERO  = {AW{1'b0}};
   localparam logic [NREGS-1:0] MASK_ZERO = {NREGS{1'b0}};
   localparam logic [NREGS-1:0] MASK_ONE  = {{(NREGS-1){1'b0}}, 1'b1};

   rr_ptr_e          ptr_q,     ptr_d;
   logic             wb_en_q,   wb_en_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic [NREGS-1:0] pending_q, pending_d;

   logic             alu_gnt_s;
   logic             lsu_gnt_s;
   logic             xfer_s;
   logic [AW-1:0]    xfer_rd_s;
   logic [XLEN-1:0]  xfer_data_s;
   logic [NREGS-1:0] clr_mask_s;
   logic [NREGS-1:0] set_mask_s;

   // Arbitration: a lone requester wins; under contention the pointer decides.
   always_comb begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
      if (alu_valid && lsu_valid) begin
         if (ptr_q == PTR_LSU) begin
            lsu_gnt_s = 1'b1;
         end else begin
            alu_gnt_s = 1'b1;
         end
      end else if (alu_valid) begin
         alu_gnt_s = 1'b1;
      end else if (lsu_valid) begin
         lsu_gnt_s = 1'b1;
      end else begin
         alu_gnt_s = 1'b0;
         lsu_gnt_s = 1'b0;
      end
   end

   // Readies are gated by reset directly so they fall the instant reset asserts,
   // without waiting for any flop to change.
   assign alu_ready = alu_gnt_s & rst;
   assign lsu_ready = lsu_gnt_s & rst;
   assign xfer_s    = alu_ready | lsu_ready;

   // Mux the winning requester's destination and data.
   always_comb begin
      xfer_rd_s   = alu_rd;
      xfer_data_s = alu_data;
      if (lsu_ready) begin
         xfer_rd_s   = lsu_rd;
         xfer_data_s = lsu_data;
      end else begin
         xfer_rd_s   = alu_rd;
         xfer_data_s = alu_data;
      end
   end

   // Pointer moves only after a contended grant; single grants leave it alone.
   always_comb begin
      ptr_d = ptr_q;
      if (alu_valid && lsu_valid) begin
         ptr_d = (ptr_q == PTR_LSU) ? PTR_ALU : PTR_LSU;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Write-port next state: a transfer to x0 is consumed without a write.
   always_comb begin
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (xfer_s) begin
         wb_en_d   = (xfer_rd_s != REG_ZERO);
         wb_addr_d = xfer_rd_s;
         wb_data_d = xfer_data_s;
      end else begin
         wb_en_d   = 1'b0;
         wb_addr_d = wb_addr_q;
         wb_data_d = wb_data_q;
      end
   end

   // Scoreboard clear mask from a transfer to a non-zero register.
   always_comb begin
      clr_mask_s = MASK_ZERO;
      if (xfer_s && (xfer_rd_s != REG_ZERO)) begin
         clr_mask_s = MASK_ONE << xfer_rd_s;
      end else begin
         clr_mask_s = MASK_ZERO;
      end
   end

   // Scoreboard set mask from an issue to a non-zero register.
   always_comb begin
      set_mask_s = MASK_ZERO;
      if (issue_valid && (issue_rd != REG_ZERO)) begin
         set_mask_s = MASK_ONE << issue_rd;
      end else begin
         set_mask_s = MASK_ZERO;
      end
   end

   // Set is applied last so it beats both a same-register clear and a flush:
   // the issuing instruction is the newest producer and is post-flush.
   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = MASK_ZERO;
      end else begin
         pending_d = pending_q & ~clr_mask_s;
      end
      pending_d = (pending_d | set_mask_s) & ~MASK_ONE;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= PTR_LSU;
         wb_en_q   <= 1'b0;
         wb_addr_q <= REG_ZERO;
         wb_data_q <= {XLEN{1'b0}};
         pending_q <= MASK_ZERO;
      end else begin
         ptr_q     <= ptr_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         pending_q <= pending_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;

   // The write-port term covers the cycle where accepted data sits in the
   // write-port registers and has not yet been stored in the register file.
   assign hazard1 = (rs1 != REG_ZERO) &
                    (pending_q[rs1] | (wb_en_q & (wb_addr_q == rs1)));
   assign hazard2 = (rs2 != REG_ZERO) &
                    (pending_q[rs2] | (wb_en_q & (wb_addr_q == rs2)));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Self-checking bench for regfile_wb_scheduler. Expected writebacks are
// pushed to a queue when the bench drives a handshake it expects to be
// accepted and are popped when the DUT raises wb_en. Grants, hazards and the
// write-port state are also checked every cycle against a small model.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        flush;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard1;
   logic        hazard2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard entries: {addr, data}.
   logic [36:0] sb_q[$];

   // Bench model state.
   logic        m_ptr_lsu;
   logic [31:0] m_pend;
   logic        m_wb_en;
   logic [4:0]  m_wb_addr;
   logic [31:0] m_wb_data;

   regfile_wb_scheduler #(.XLEN(32), .NREGS(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_ptr_lsu = 1'b1;
      m_pend    = 32'd0;
      m_wb_en   = 1'b0;
      m_wb_addr = 5'd0;
      m_wb_data = 32'd0;
      sb_q.delete();
   endtask

   // One clock cycle: drive at the falling edge, check combinational outputs,
   // advance the model across the rising edge, check the write port.
   task automatic drive_cycle(
      input logic av, input logic [4:0] ard, input logic [31:0] ad,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
      input logic iv, input logic [4:0] ird, input logic fl,
      input logic [4:0] r1, input logic [4:0] r2);
      logic        g_a, g_l, xf, h1, h2;
      logic [4:0]  x_rd;
      logic [31:0] x_d, pend_n;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      issue_valid = iv; issue_rd = ird; flush = fl;
      rs1 = r1; rs2 = r2;
      #1;
      g_a = av && (!lv || !m_ptr_lsu);
      g_l = lv && (!av ||  m_ptr_lsu);
      check_eq("alu_ready", alu_ready, g_a);
      check_eq("lsu_ready", lsu_ready, g_l);
      h1 = (r1 != 5'd0) && (m_pend[r1] || (m_wb_en && m_wb_addr == r1));
      h2 = (r2 != 5'd0) && (m_pend[r2] || (m_wb_en && m_wb_addr == r2));
      check_eq("hazard1", hazard1, h1);
      check_eq("hazard2", hazard2, h2);
      assert (!(iv && ird != 5'd0 && m_pend[ird]))
         else $error("illegal issue to pending register x%0d", ird);
      xf   = g_a || g_l;
      x_rd = g_l ? lrd : ard;
      x_d  = g_l ? ld  : ad;
      if (xf && x_rd != 5'd0) sb_q.push_back({x_rd, x_d});
      pend_n = fl ? 32'd0 : m_pend;
      if (xf && x_rd != 5'd0) pend_n[x_rd] = 1'b0;
      if (iv && ird != 5'd0)  pend_n[ird]  = 1'b1;
      pend_n[0] = 1'b0;
      @(posedge clk);
      m_pend = pend_n;
      if (av && lv) m_ptr_lsu = ~m_ptr_lsu;
      if (xf) begin
         m_wb_en = (x_rd != 5'd0); m_wb_addr = x_rd; m_wb_data = x_d;
      end else begin
         m_wb_en = 1'b0;
      end
      @(negedge clk);
      check_eq("wb_en",   wb_en,   m_wb_en);
      check_eq("wb_addr", wb_addr, m_wb_addr);
      check_eq("wb_data", wb_data, m_wb_data);
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r1, r2);
   endtask

   // Scoreboard consumer: every write seen on the port must be the next expected one.
   always @(posedge clk) begin
      logic [36:0] e;
      #1;
      if (rst && wb_en) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_addr", wb_addr, {27'd0, e[36:32]});
            check_eq("sb_data", wb_data, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
      issue_valid = 1'b0; issue_rd = 5'd0; flush = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
      model_reset();
      #7;
      check_eq("rst_alu_ready", alu_ready, 32'd0);
      check_eq("rst_lsu_ready", lsu_ready, 32'd0);
      check_eq("rst_wb_en",     wb_en,     32'd0);
      check_eq("rst_wb_addr",   wb_addr,   32'd0);
      check_eq("rst_wb_data",   wb_data,   32'd0);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Single ALU writeback.
      drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      check_eq("t1_wb_addr", wb_addr, 32'd5);
      check_eq("t1_wb_data", wb_data, 32'hDEADBEEF);
      idle(5'd0, 5'd0);
      check_eq("t1_wb_en_off", wb_en, 32'd0);

      // Contention twice: LSU first both times.
      for (int rep = 0; rep < 2; rep++) begin
         drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
         check_eq("rr_first_addr", wb_addr, 32'd4);
         drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd6, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
         check_eq("rr_second_addr", wb_addr, 32'd3);
         drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
         idle(5'd0, 5'd0);
      end

      // RAW hazard on x7 through pending bit then write-port term.
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
      idle(5'd7, 5'd0);
      check_eq("t3_haz_pending", hazard1, 32'd1);
      drive_cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
      check_eq("t3_haz_wb", hazard1, 32'd1);
      idle(5'd7, 5'd0);
      check_eq("t3_haz_clear", hazard1, 32'd0);

      // Issue to x9 on the same edge as an LSU transfer to x9: set wins.
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
      idle(5'd0, 5'd9);
      idle(5'd0, 5'd9);
      check_eq("t4_haz2_held", hazard2, 32'd1);

      // Transfer to x0: accepted, never written.
      drive_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      check_eq("t5_wb_en", wb_en, 32'd0);
      check_eq("t5_haz1", hazard1, 32'd0);
      idle(5'd0, 5'd0);

      // Pending x1..x3, then flush.
      for (int r = 1; r <= 3; r++) begin
         drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 5'd1, 5'd2);
      end
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd3);
      idle(5'd1, 5'd2);
      idle(5'd3, 5'd9);
      check_eq("t6_flush_haz", {30'd0, hazard1, hazard2}, 32'd0);

      // Contention leaves the pointer at ALU, then reset mid-transfer.
      drive_cycle(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      check_eq("t7_pre_wb_en", wb_en, 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA;
      lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hCCCC;
      #2;
      rst = 1'b0;
      #1;
      check_eq("t7_alu_ready", alu_ready, 32'd0);
      check_eq("t7_lsu_ready", lsu_ready, 32'd0);
      check_eq("t7_wb_en",     wb_en,     32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_eq("t7_wb_en_hold", wb_en, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive_cycle(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd12, 32'hCCCC, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      check_eq("t7_lsu_after_rst", wb_addr, 32'd12);
      drive_cycle(1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);

      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 integer register file.
- Arbitrates writeback between the ALU and the load/store unit (LSU) using a valid/ready handshake and drives the registered write port.
- Keeps a per-register pending scoreboard that lets decode detect read-after-write hazards on rs1/rs2 before reading the register file.

Parameters:
- XLEN, 32, data width of registers and writeback data.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width; must satisfy 2**AW = NREGS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result available.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- lsu_valid  in  1  load data available.
- lsu_rd  in  AW  load destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  load result accepted this cycle.
- issue_valid  in  1  decode issues an instruction that writes rd.
- issue_rd  in  AW  destination of the issued instruction.
- flush  in  1  pipeline flush; synchronous clear of the scoreboard.
- rs1  in  AW  decode source register 1.
- rs2  in  AW  decode source register 2.
- hazard1  out  1  rs1 value in the register file is not yet valid.
- hazard2  out  1  rs2 value in the register file is not yet valid.
- wb_en  out  1  register-file writeEnable.
- wb_addr  out  AW  register-file writeAddr.
- wb_data  out  XLEN  register-file writeData.

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_en=0, wb_addr=0, wb_data=0.
  - pending[NREGS-1:0]=0.
  - Round-robin pointer set to LSU.
  - alu_ready and lsu_ready are forced to 0 while rst=0.
  - Reset asserted mid-transfer discards the transfer; no write reaches the register file after reset asserts.
- Arbitration (combinational, one grant per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted; the pointer then moves to the other requester.
  - Single-requester grants leave the pointer unchanged.
  - ready = grant. A transfer occurs when valid & ready.
  - A requester holds valid, rd and data stable until it sees ready.
- Write port (registered, 1-cycle latency):
  - On a transfer edge: wb_en<=(rd!=0), wb_addr<=rd, wb_data<=data.
  - With no transfer: wb_en<=0; wb_addr and wb_data hold their values.
  - The register file performs the write on the next edge, so acceptance to architectural visibility is 2 edges.
  - Transfers with rd=0 are consumed and never assert wb_en.
- Scoreboard:
  - Set: issue_valid & issue_rd!=0 sets pending[issue_rd] on the edge.
  - Clear: a transfer with rd!=0 clears pending[rd] on the same edge.
  - Set and clear of the same register on the same edge: set wins, because the newer producer owns the register.
  - flush=1 clears all bits. A set in the same cycle as flush still applies, because the issuing instruction is post-flush.
  - Issuing to a register whose pending bit is already 1 is illegal; decode must stall. The bench flags it as an assertion.
  - pending[0] is constantly 0.
- Hazard outputs (combinational):
  - hazardN = (rsN!=0) & (pending[rsN] | (wb_en & wb_addr==rsN)).
  - The wb_en term covers the cycle in which the write-port registers hold data not yet stored in the register file.
  - x0 never raises a hazard.
- Transfers are not blocked by flush: in-flight writebacks still commit.

Test Plan:
- Reset, then only alu_valid with rd=5 and data=0xDEADBEEF: alu_ready=1 in the same cycle; next cycle wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; the cycle after, wb_en=0.
- ALU (rd=3, data=0x11) and LSU (rd=4, data=0x22) both valid for 2 cycles:
  - Cycle 0: LSU granted.
  - Cycle 1: ALU granted.
  - Required wb sequence: (4, 0x22) then (3, 0x11).
  - Repeating the contention grants LSU first again, confirming the pointer alternates.
- issue_valid with issue_rd=7, rs1=7:
  - hazard1=1 from the next cycle until the ALU transfer for rd=7.
  - hazard1 stays 1 in the following cycle (wb_en term).
  - hazard1 drops to 0 one cycle later.
- issue_rd=9 issued in the same cycle as an LSU transfer to rd=9: pending[9] remains 1 and hazard2 (rs2=9) stays 1.
- ALU transfer with rd=0 and data=0xFFFFFFFF: alu_ready=1, wb_en stays 0; rs1=0 gives hazard1=0 throughout.
- pending set for x1, x2, x3; assert flush: all hazards drop the next cycle. Then assert rst mid-transfer with both valid: readies drop immediately, wb_en=0 asynchronously, and after release the pointer favours LSU.
